emif_amm_arb: RTL

- Two-requester arbiter in front of the EMIF user Avalon-MM port (ctrl_amm_0) in the mc_top memory-controller path.
- Arbitrates reads and writes round-robin and holds the grant for the full duration of a multi-beat write burst.
- Tracks outstanding read bursts in a response FIFO and steers amm_readdatavalid back to the requester that issued the read.
- Runs entirely in the emif_usr_clk domain.

---
 rtl/emif_amm_arb.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/emif_amm_arb.sv
// Two-port round-robin arbiter in front of the EMIF user Avalon-MM port.
// Holds the grant across write bursts and routes read beats back via a response FIFO.
module emif_amm_arb #(
    parameter int DATA_W    = 576,
    parameter int ADDR_W    = 28,
    parameter int BCNT_W    = 7,
    parameter int RSP_DEPTH = 16
) (
    input  logic              emif_usr_clk,
    input  logic              emif_usr_reset_n,
    input  logic              req0_read,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_address,
    input  logic [DATA_W-1:0] req0_writedata,
    input  logic [BCNT_W-1:0] req0_burstcount,
    output logic              req0_ready,
    output logic [DATA_W-1:0] req0_readdata,
    output logic              req0_readdatavalid,
    input  logic              req1_read,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_address,
    input  logic [DATA_W-1:0] req1_writedata,
    input  logic [BCNT_W-1:0] req1_burstcount,
    output logic              req1_ready,
    output logic [DATA_W-1:0] req1_readdata,
    output logic              req1_readdatavalid,
    input  logic              amm_ready,
    output logic              amm_read,
    output logic              amm_write,
    output logic [ADDR_W-1:0] amm_address,
    output logic [DATA_W-1:0] amm_writedata,
    output logic [BCNT_W-1:0] amm_burstcount,
    input  logic [DATA_W-1:0] amm_readdata,
    input  logic              amm_readdatavalid,
    output logic              rsp_err
);

    localparam int AW = $clog2(RSP_DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        WBURST = 1'b1
    } state_t;

    state_t            state, state_d;
    logic              rr_ptr, rr_d;
    logic              lock_port, lock_d;
    logic [BCNT_W-1:0] wr_left, wr_left_d;

    logic              fifo_port [RSP_DEPTH];
    logic [BCNT_W-1:0] fifo_bcnt [RSP_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic [BCNT_W-1:0] beat_cnt;

    logic              full, empty;
    logic [1:0]        rd, wr, elig;
    logic              gnt, g_rd, g_wr, rdy_g;
    logic              amm_read_c, amm_write_c;
    logic              acc, push, wr_acc;
    logic [BCNT_W-1:0] bc_eff;
    logic              vld, pop;
    logic [BCNT_W-1:0] head_bc;

    assign full  = (count == (AW+1)'(RSP_DEPTH));
    assign empty = (count == '0);
    assign rd    = {req1_read, req0_read};
    assign wr    = {req1_write, req0_write};
    assign elig  = wr | (rd & {2{~full}});

    always_comb begin
        gnt = rr_ptr;
        if (state == WBURST)
            gnt = lock_port;
        else if (elig[0] && elig[1])
            gnt = rr_ptr;
        else if (elig[1])
            gnt = 1'b1;
        else if (elig[0])
            gnt = 1'b0;
    end

    assign g_rd           = rd[gnt];
    assign g_wr           = wr[gnt];
    assign amm_address    = gnt ? req1_address    : req0_address;
    assign amm_writedata  = gnt ? req1_writedata  : req0_writedata;
    assign amm_burstcount = gnt ? req1_burstcount : req0_burstcount;

    // A read from the locked port mid-burst is neither issued nor acknowledged.
    always_comb begin
        amm_read_c  = 1'b0;
        amm_write_c = g_wr;
        rdy_g       = amm_ready;
        if (state == IDLE) begin
            amm_read_c = g_rd & ~full;
            rdy_g      = amm_ready & ~(g_rd & full);
        end else begin
            rdy_g      = amm_ready & ~g_rd;
        end
    end

    assign amm_read   = amm_read_c  & emif_usr_reset_n;
    assign amm_write  = amm_write_c & emif_usr_reset_n;
    assign req0_ready = rdy_g & ~gnt & emif_usr_reset_n;
    assign req1_ready = rdy_g &  gnt & emif_usr_reset_n;

    assign acc    = amm_ready & (amm_read | amm_write);
    assign push   = acc & amm_read;
    assign wr_acc = acc & amm_write;
    assign bc_eff = (amm_burstcount == '0) ? BCNT_W'(1) : amm_burstcount;

    always_comb begin
        state_d   = state;
        rr_d      = rr_ptr;
        lock_d    = lock_port;
        wr_left_d = wr_left;
        unique case (state)
            IDLE: begin
                if (push)
                    rr_d = ~gnt;
                if (wr_acc) begin
                    if (bc_eff > BCNT_W'(1)) begin
                        lock_d    = gnt;
                        wr_left_d = bc_eff - BCNT_W'(1);
                        state_d   = WBURST;
                    end else begin
                        rr_d = ~gnt;
                    end
                end
            end
            WBURST: begin
                if (wr_acc) begin
                    wr_left_d = wr_left - BCNT_W'(1);
                    if (wr_left == BCNT_W'(1)) begin
                        rr_d    = ~lock_port;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
        if (!emif_usr_reset_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            lock_port <= 1'b0;
            wr_left   <= '0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_d;
            lock_port <= lock_d;
            wr_left   <= wr_left_d;
        end
    end

    assign head_bc = fifo_bcnt[rd_ptr];
    assign vld     = amm_readdatavalid & ~empty;
    assign pop     = vld & ((beat_cnt + BCNT_W'(1)) == head_bc);

    assign req0_readdata      = amm_readdata;
    assign req1_readdata      = amm_readdata;
    assign req0_readdatavalid = vld & ~fifo_port[rd_ptr];
    assign req1_readdatavalid = vld &  fifo_port[rd_ptr];

    always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
        if (!emif_usr_reset_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_port[i] <= 1'b0;
                fifo_bcnt[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_cnt <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (push) begin
                fifo_port[wr_ptr] <= gnt;
                fifo_bcnt[wr_ptr] <= bc_eff;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                beat_cnt <= '0;
            end else if (vld) begin
                beat_cnt <= beat_cnt + BCNT_W'(1);
            end
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
            if (amm_readdatavalid && empty)
                rsp_err <= 1'b1;
        end
    end

endmodule
